// File: rtl/genome_writeback_pkg.sv
// Shared definitions for the genome writeback stage: phase encoding,
// header layout and FSM state encoding.
package genome_writeback_pkg;

  localparam int GENE_SZ_DEF = 64;
  localparam int ATTR_SZ_DEF = 8;

  typedef enum logic {
    PH_NODE = 1'b0,
    PH_CONN = 1'b1
  } phase_e;

  // Flag bits are counted down from the header MSB; count fields are in
  // units of CNT_SZ from bit 0.
  localparam int HDR_OVF_FROM_MSB = 0;
  localparam int HDR_ORD_FROM_MSB = 1;
  localparam int HDR_NODE_FIELD   = 1;
  localparam int HDR_CONN_FIELD   = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NODES  = 2'd1,
    S_CONNS  = 2'd2,
    S_HEADER = 2'd3
  } wb_state_e;

endpackage

// File: rtl/genome_writeback.sv
// Packs surviving genes from the deletion stage contiguously into genome
// memory, then closes the genome with a header of counts and error flags.
module genome_writeback
  import genome_writeback_pkg::*;
#(
  parameter int GENE_SZ   = GENE_SZ_DEF,
  parameter int ADDR_SZ   = 10,
  parameter int CNT_SZ    = 8,
  parameter int MAX_GENES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_SZ-1:0] base_addr,
  input  logic               state,
  input  logic [GENE_SZ-1:0] gene_in,
  input  logic               in_valid,
  input  logic               last_in,
  output logic               mem_we,
  output logic [ADDR_SZ-1:0] mem_addr,
  output logic [GENE_SZ-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic [CNT_SZ-1:0]  node_cnt,
  output logic [CNT_SZ-1:0]  conn_cnt,
  output logic               overflow,
  output logic               order_err
);

  wb_state_e          fsm_q, fsm_d;
  logic [ADDR_SZ-1:0] base_q;
  logic [CNT_SZ-1:0]  wr_ptr;

  logic in_phase, order_drop, full, take, ovf_hit, as_conn;

  function automatic logic [GENE_SZ-1:0] make_header(
    input logic ovf, input logic ord,
    input logic [CNT_SZ-1:0] nodes, input logic [CNT_SZ-1:0] conns);
    logic [GENE_SZ-1:0] h;
    h = '0;
    h[GENE_SZ-1-HDR_OVF_FROM_MSB] = ovf;
    h[GENE_SZ-1-HDR_ORD_FROM_MSB] = ord;
    h[HDR_NODE_FIELD*CNT_SZ +: CNT_SZ] = nodes;
    h[HDR_CONN_FIELD*CNT_SZ +: CNT_SZ] = conns;
    return h;
  endfunction

  always_comb begin
    fsm_d    = fsm_q;
    as_conn  = 1'b0;
    in_phase = (fsm_q == S_NODES) || (fsm_q == S_CONNS);
    case (fsm_q)
      S_IDLE: begin
        if (start) fsm_d = S_NODES;
      end
      S_NODES: begin
        // A connection-phase slot switches phase even when the gene itself was deleted.
        as_conn = (phase_e'(state) == PH_CONN);
        if (as_conn) fsm_d = S_CONNS;
        if (last_in) fsm_d = S_HEADER;
      end
      S_CONNS: begin
        as_conn = 1'b1;
        if (last_in) fsm_d = S_HEADER;
      end
      S_HEADER: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
    order_drop = (fsm_q == S_CONNS) && in_valid && (phase_e'(state) == PH_NODE);
    full       = (wr_ptr == CNT_SZ'(MAX_GENES));
    take       = in_phase && in_valid && !order_drop && !full;
    ovf_hit    = in_phase && in_valid && !order_drop && full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      base_q    <= '0;
      wr_ptr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      node_cnt  <= '0;
      conn_cnt  <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            wr_ptr    <= '0;
            node_cnt  <= '0;
            conn_cnt  <= '0;
            overflow  <= 1'b0;
            order_err <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_NODES, S_CONNS: begin
          if (take) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_q + ADDR_SZ'(1) + ADDR_SZ'(wr_ptr);
            mem_wdata <= gene_in;
            wr_ptr    <= wr_ptr + CNT_SZ'(1);
            if (as_conn) conn_cnt <= conn_cnt + CNT_SZ'(1);
            else         node_cnt <= node_cnt + CNT_SZ'(1);
          end
          if (ovf_hit)    overflow  <= 1'b1;
          if (order_drop) order_err <= 1'b1;
        end
        S_HEADER: begin
          mem_we    <= 1'b1;
          mem_addr  <= base_q;
          mem_wdata <= make_header(overflow, order_err, node_cnt, conn_cnt);
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_genome_writeback.sv
// Scoreboard bench for genome_writeback: a reference model queues the
// expected memory writes, a monitor compares them as the DUT emits them.
module tb_genome_writeback;

  localparam int GW = 64;
  localparam int AW = 10;
  localparam int CW = 8;
  localparam int MAXG = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          state = 1'b0;
  logic [GW-1:0] gene_in = '0;
  logic          in_valid = 1'b0;
  logic          last_in = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [GW-1:0] mem_wdata;
  logic          busy, done;
  logic [CW-1:0] node_cnt, conn_cnt;
  logic          overflow, order_err;

  genome_writeback #(.GENE_SZ(GW), .ADDR_SZ(AW), .CNT_SZ(CW), .MAX_GENES(MAXG)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .state(state),
    .gene_in(gene_in), .in_valid(in_valid), .last_in(last_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .node_cnt(node_cnt), .conn_cnt(conn_cnt),
    .overflow(overflow), .order_err(order_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [GW-1:0] data;
    int            at;
    bit            hdr;
    int            nc, cc;
    bit            ovf, ord;
  } exp_t;

  typedef struct {
    bit            v, st, last, stp;
    logic [GW-1:0] g;
    logic [AW-1:0] sbase;
  } slot_t;

  exp_t  sb[$];
  slot_t slots[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {54'd0, mem_addr}, '1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", {54'd0, mem_addr}, {54'd0, e.addr});
        chk("wr_data", mem_wdata, e.data);
        chk("wr_cycle", 64'(cyc), 64'(e.at));
        chk("done_with_write", {63'd0, done}, {63'd0, e.hdr});
        if (e.hdr) begin
          chk("node_cnt", {56'd0, node_cnt}, 64'(e.nc));
          chk("conn_cnt", {56'd0, conn_cnt}, 64'(e.cc));
          chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
          chk("order_err", {63'd0, order_err}, {63'd0, e.ord});
        end
      end
    end else if (done) begin
      chk("done_without_write", {63'd0, done}, 64'd0);
    end
  end

  task automatic drive(input bit st_p, input logic [AW-1:0] b, input bit v, input bit ph,
                       input logic [GW-1:0] g, input bit last);
    @(posedge clk); #1;
    start = st_p; base_addr = b; in_valid = v; state = ph; gene_in = g; last_in = last;
  endtask

  // Reference model: applies the packing rules slot by slot and queues
  // the writes (and header) the DUT must produce.
  task automatic run_genome(input logic [AW-1:0] base, input bit do_last);
    bit conn_phase = 0;
    int wr = 0, nc = 0, cc = 0;
    bit ovf = 0, ord = 0;
    exp_t e;
    drive(1, base, 0, 0, '0, 0);
    drive(0, '0, 0, 0, '0, 0);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    foreach (slots[i]) begin
      drive(slots[i].stp, slots[i].sbase, slots[i].v, slots[i].st, slots[i].g, slots[i].last);
      if (slots[i].st) conn_phase = 1;
      if (slots[i].v) begin
        if (conn_phase && !slots[i].st) ord = 1;
        else if (wr == MAXG) ovf = 1;
        else begin
          e = '{addr: base + AW'(1) + AW'(wr), data: slots[i].g, at: cyc + 1,
                hdr: 0, nc: 0, cc: 0, ovf: 0, ord: 0};
          sb.push_back(e);
          wr++;
          if (slots[i].st) cc++; else nc++;
        end
      end
      if (slots[i].last && do_last) begin
        e.addr = base;
        e.data = '0;
        e.data[63] = ovf;
        e.data[62] = ord;
        e.data[15:8] = CW'(nc);
        e.data[7:0] = CW'(cc);
        e.at = cyc + 2;
        e.hdr = 1; e.nc = nc; e.cc = cc; e.ovf = ovf; e.ord = ord;
        sb.push_back(e);
        break;
      end
    end
    drive(0, '0, 0, 0, '0, 0);
    drive(0, '0, 0, 0, '0, 0);
  endtask

  function automatic slot_t mk(input bit v, input bit st, input bit last);
    slot_t s;
    s.v = v; s.st = st; s.last = last; s.stp = 0; s.sbase = '0;
    s.g = {$urandom, $urandom};
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_counts", {48'd0, node_cnt, conn_cnt}, 64'd0);
    chk("rst_flags", {62'd0, overflow, order_err}, 64'd0);
    chk("rst_addr_data", {54'd0, mem_addr} | mem_wdata, 64'd0);
    rst = 0;

    // Basic genome: 3 nodes then 2 connections.
    slots.delete();
    for (int i = 0; i < 3; i++) slots.push_back(mk(1, 0, 0));
    slots.push_back(mk(1, 1, 0));
    slots.push_back(mk(1, 1, 1));
    run_genome(10'h040, 1);

    // Deleted slots interleaved, last on an invalid slot.
    slots.delete();
    slots.push_back(mk(1, 0, 0)); slots.push_back(mk(0, 0, 0));
    slots.push_back(mk(1, 0, 0)); slots.push_back(mk(0, 1, 0));
    slots.push_back(mk(1, 1, 0)); slots.push_back(mk(0, 1, 0));
    slots.push_back(mk(1, 1, 0)); slots.push_back(mk(0, 1, 1));
    run_genome(10'h100, 1);

    // Overflow: MAXG+2 node genes.
    slots.delete();
    for (int i = 0; i < MAXG + 2; i++) slots.push_back(mk(1, 0, i == MAXG + 1));
    run_genome(10'h200, 1);

    // Order error: node, conn, then a late node gene.
    slots.delete();
    slots.push_back(mk(1, 0, 0)); slots.push_back(mk(1, 1, 0)); slots.push_back(mk(1, 0, 1));
    run_genome(10'h300, 1);

    // Zero-gene genome, with an address wrap on the next one.
    slots.delete();
    slots.push_back(mk(0, 0, 1));
    run_genome(10'h3FF, 1);

    // Start while busy must be ignored.
    slots.delete();
    slots.push_back(mk(1, 0, 0));
    slots.push_back(mk(1, 0, 0));
    slots[1].stp = 1; slots[1].sbase = 10'h155;
    slots.push_back(mk(1, 1, 1));
    run_genome(10'h3FE, 1);

    // Randomized genomes.
    for (int n = 0; n < 30; n++) begin
      int len, sw;
      slots.delete();
      len = $urandom_range(1, 13);
      sw  = $urandom_range(0, len);
      for (int i = 0; i < len; i++) begin
        slot_t s;
        s = mk($urandom_range(0, 3) != 0, i >= sw, i == len - 1);
        if (i > sw && $urandom_range(0, 9) == 0) s.st = 0;
        if ($urandom_range(0, 9) == 0) begin s.stp = 1; s.sbase = AW'($urandom); end
        slots.push_back(s);
      end
      run_genome(AW'($urandom), 1);
    end

    // Reset after two writes abandons the genome.
    slots.delete();
    slots.push_back(mk(1, 0, 0)); slots.push_back(mk(1, 0, 0));
    slots.push_back(mk(1, 0, 0));
    begin
      logic [AW-1:0] b;
      b = 10'h080;
      drive(1, b, 0, 0, '0, 0);
      drive(0, '0, slots[0].v, 0, slots[0].g, 0);
      sb.push_back('{addr: b + 1, data: slots[0].g, at: cyc + 1, hdr: 0, nc: 0, cc: 0, ovf: 0, ord: 0});
      drive(0, '0, slots[1].v, 0, slots[1].g, 0);
      sb.push_back('{addr: b + 2, data: slots[1].g, at: cyc + 1, hdr: 0, nc: 0, cc: 0, ovf: 0, ord: 0});
      drive(0, '0, slots[2].v, 0, slots[2].g, 1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0; in_valid = 0; last_in = 0;
      chk("midrst_mem_we", {63'd0, mem_we}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_counts", {48'd0, node_cnt, conn_cnt}, 64'd0);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
